uart_rx: RTL and testbench

- 8N1 UART receiver; companion to the transmit-only UART on the same serial link.
- Oversamples the asynchronous serial input 16x using a fractional-accumulator baud tick.
- Recovers bytes LSB-first and presents each byte on a hold-until-read handshake to the system bus side.
- Flags framing error, overrun and (optionally) parity error.

---
 rtl/uart_pkg.sv | 28 ++
 rtl/uart_baud_tick.sv | 35 +++
 rtl/uart_rx.sv | 181 ++++++++++++++++++
 tb/tb_uart_rx.sv | 270 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared constants, FSM state type and the vote helper for the UART receiver.
// Also intended for reuse by the companion transmitter.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP,
    BREAK
  } rx_state_e;

  localparam int OVERSAMPLE = 16;
  localparam int DATA_BITS  = 8;

  // Tick positions inside a 16-tick bit window; the count restarts at each bit boundary.
  localparam logic [3:0] MID_TICK  = 4'd8;
  localparam logic [3:0] LAST_TICK = 4'd15;
  localparam logic [3:0] VOTE_T0   = 4'd7;
  localparam logic [3:0] VOTE_T1   = 4'd8;
  localparam logic [3:0] VOTE_T2   = 4'd9;

  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Fractional phase accumulator producing a one-clock tick at BAUD*OVERSAMPLE Hz.
// The accumulator free-runs from reset.
module uart_baud_tick #(
  parameter int CLK_HZ     = 68000000,
  parameter int BAUD       = 115200,
  parameter int OVERSAMPLE = 16,
  parameter int ACC_W      = 32
) (
  input  logic sys_clk_i,
  input  logic sys_rst_n_i,
  output logic baud_tick
);

  localparam logic [ACC_W-1:0] INC = ACC_W'(BAUD * OVERSAMPLE);
  localparam logic [ACC_W-1:0] MOD = ACC_W'(CLK_HZ);

  logic [ACC_W-1:0] acc_q;
  logic [ACC_W-1:0] sum;

  assign sum = acc_q + INC;

  always_ff @(posedge sys_clk_i) begin
    if (!sys_rst_n_i) begin
      acc_q     <= '0;
      baud_tick <= 1'b0;
    end else if (sum >= MOD) begin
      acc_q     <= sum - MOD;
      baud_tick <= 1'b1;
    end else begin
      acc_q     <= sum;
      baud_tick <= 1'b0;
    end
  end

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver, 16x oversampled, with hold-until-read byte handshake.
// Define UART_RX_PARITY_EN to receive an even-parity bit between data and stop.
module uart_rx #(
  parameter int CLK_HZ     = 68000000,
  parameter int BAUD       = 115200,
  parameter int OVERSAMPLE = 16,
  parameter int ACC_W      = 32
) (
  input  logic       sys_clk_i,
  input  logic       sys_rst_n_i,
  input  logic       uart_rx_i,
  input  logic       uart_rd_i,
  output logic [7:0] uart_dat_o,
  output logic       uart_valid_o,
  output logic       uart_ferr_o,
  output logic       uart_perr_o,
  output logic       uart_ovr_o,
  output logic       uart_busy
);
  import uart_pkg::*;

  localparam logic [2:0] LAST_BIT = 3'(DATA_BITS - 1);

  logic       rx_meta;
  logic       rx_s;
  logic       rx_s_d;
  logic       fall;
  logic       tick;
  rx_state_e  state_q;
  rx_state_e  state_d;
  logic [3:0] cnt_q;
  logic [2:0] bit_idx_q;
  logic       start_ok_q;
  logic [1:0] vote_q;
  logic [7:0] shreg_q;
  logic       stop_hit;
  logic       commit_vld_p1;
  logic       commit_ferr_p1;

  uart_baud_tick #(
    .CLK_HZ    (CLK_HZ),
    .BAUD      (BAUD),
    .OVERSAMPLE(OVERSAMPLE),
    .ACC_W     (ACC_W)
  ) u_tick (
    .sys_clk_i  (sys_clk_i),
    .sys_rst_n_i(sys_rst_n_i),
    .baud_tick  (tick)
  );

  always_ff @(posedge sys_clk_i) begin
    if (!sys_rst_n_i) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
      rx_s_d  <= 1'b1;
    end else begin
      rx_meta <= uart_rx_i;
      rx_s    <= rx_meta;
      rx_s_d  <= rx_s;
    end
  end

  assign fall = rx_s_d & ~rx_s;

  always_ff @(posedge sys_clk_i) begin
    if (!sys_rst_n_i) state_q <= IDLE;
    else              state_q <= state_d;
  end

  always_comb begin
    state_d  = state_q;
    stop_hit = 1'b0;
    case (state_q)
      IDLE: begin
        if (fall) state_d = START;
      end
      // START spans the whole start bit so bit windows stay aligned to line edges.
      START: begin
        if (tick && cnt_q == MID_TICK && rx_s) state_d = IDLE;
        else if (tick && cnt_q == LAST_TICK)   state_d = DATA;
      end
      DATA: begin
        if (tick && cnt_q == LAST_TICK && bit_idx_q == LAST_BIT) begin
`ifdef UART_RX_PARITY_EN
          state_d = PARITY;
`else
          state_d = STOP;
`endif
        end
      end
      PARITY: begin
        if (tick && cnt_q == LAST_TICK) state_d = STOP;
      end
      STOP: begin
        if (tick && cnt_q == MID_TICK) begin
          stop_hit = 1'b1;
          state_d  = rx_s ? IDLE : BREAK;
        end
      end
      BREAK: begin
        if (rx_s) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge sys_clk_i) begin
    if (!sys_rst_n_i) begin
      cnt_q          <= '0;
      bit_idx_q      <= '0;
      start_ok_q     <= 1'b0;
      commit_vld_p1  <= 1'b0;
      commit_ferr_p1 <= 1'b0;
    end else begin
      commit_vld_p1 <= stop_hit;
      if (stop_hit) commit_ferr_p1 <= ~rx_s;
      if (state_q == IDLE) begin
        cnt_q      <= '0;
        bit_idx_q  <= '0;
        start_ok_q <= 1'b0;
      end else if (tick) begin
        cnt_q <= cnt_q + 4'd1;
        if (state_q == START && cnt_q == MID_TICK && !rx_s) start_ok_q <= 1'b1;
        if (state_q == DATA && cnt_q == LAST_TICK) bit_idx_q <= bit_idx_q + 3'd1;
      end
    end
  end

  // Majority vote over three consecutive ticks around each bit centre.
  always_ff @(posedge sys_clk_i) begin
    if (tick) begin
      if (cnt_q == VOTE_T0) vote_q[0] <= rx_s;
      if (cnt_q == VOTE_T1) vote_q[1] <= rx_s;
      if (cnt_q == VOTE_T2 && state_q == DATA)
        shreg_q <= {maj3(vote_q[0], vote_q[1], rx_s), shreg_q[7:1]};
    end
  end

  // Commit stage: one clock after the stop-bit sample.
  always_ff @(posedge sys_clk_i) begin
    if (!sys_rst_n_i) begin
      uart_dat_o   <= '0;
      uart_valid_o <= 1'b0;
      uart_ferr_o  <= 1'b0;
      uart_ovr_o   <= 1'b0;
    end else if (commit_vld_p1) begin
      uart_dat_o   <= shreg_q;
      uart_ferr_o  <= commit_ferr_p1;
      uart_valid_o <= 1'b1;
      if (uart_valid_o && !uart_rd_i) uart_ovr_o <= 1'b1;
    end else if (uart_rd_i && uart_valid_o) begin
      uart_valid_o <= 1'b0;
      uart_ferr_o  <= 1'b0;
      uart_ovr_o   <= 1'b0;
    end
  end

`ifdef UART_RX_PARITY_EN
  logic par_q;
  logic perr_q;

  always_ff @(posedge sys_clk_i) begin
    if (tick && cnt_q == VOTE_T2 && state_q == PARITY)
      par_q <= maj3(vote_q[0], vote_q[1], rx_s);
  end

  always_ff @(posedge sys_clk_i) begin
    if (!sys_rst_n_i)                     perr_q <= 1'b0;
    else if (commit_vld_p1)               perr_q <= (^shreg_q) ^ par_q;
    else if (uart_rd_i && uart_valid_o)   perr_q <= 1'b0;
  end

  assign uart_perr_o = perr_q;
`else
  assign uart_perr_o = 1'b0;
`endif

  assign uart_busy = (state_q == DATA) || (state_q == PARITY) || (state_q == STOP) ||
                     (state_q == START && start_ok_q);

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx: table of frames plus glitch, break, overrun and reset sequences.
// Runs the receiver at a scaled-down clock so a bit is ~148 clocks.
`timescale 1ns/1ps
module tb_uart_rx;

  localparam int  CLK_HZ_TB = 17000000;
  localparam int  BAUD_TB   = 115200;
  localparam int  BIT       = 148;
  localparam int  FAST      = 143;
  localparam int  SLOW      = 152;
  localparam real BIT_R     = 17000000.0 / 115200.0;
`ifdef UART_RX_PARITY_EN
  localparam int PARITY_ON = 1;
`else
  localparam int PARITY_ON = 0;
`endif

  typedef struct {
    logic [7:0] data;
    logic       par;
    logic       stop;
    int         bclk;
    logic [7:0] exp_dat;
    logic       exp_ferr;
    logic       exp_perr;
  } vec_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       rx = 1'b1;
  logic       rd = 1'b0;
  logic [7:0] dat;
  logic       valid, ferr, perr, ovr, busy;

  int   total = 0;
  int   bad = 0;
  int   cyc = 0;
  int   nvalid = 0;
  int   rise_cyc = 0;
  int   edge_cyc = 0;
  logic vprev = 1'b0;

  always #5 clk = ~clk;

  uart_rx #(.CLK_HZ(CLK_HZ_TB), .BAUD(BAUD_TB), .OVERSAMPLE(16), .ACC_W(32)) dut (
    .sys_clk_i   (clk),
    .sys_rst_n_i (rst_n),
    .uart_rx_i   (rx),
    .uart_rd_i   (rd),
    .uart_dat_o  (dat),
    .uart_valid_o(valid),
    .uart_ferr_o (ferr),
    .uart_perr_o (perr),
    .uart_ovr_o  (ovr),
    .uart_busy   (busy)
  );

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    vprev <= valid;
    if (valid && !vprev) begin
      nvalid   <= nvalid + 1;
      rise_cyc <= cyc;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic check_rng(input string name, input int val, input int lo, input int hi);
    total++;
    if (val < lo || val > hi) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d..%0d", name, val, lo, hi);
    end
  endtask

  task automatic tick_to(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic drive_bit(input logic lvl, input int n);
    rx = lvl;
    tick_to(n);
  endtask

  task automatic send_frame(input logic [7:0] d, input logic par, input logic stop, input int b);
    edge_cyc = cyc;
    drive_bit(1'b0, b);
    for (int i = 0; i < 8; i++) drive_bit(d[i], b);
    if (PARITY_ON != 0) drive_bit(par, b);
    drive_bit(stop, b);
    rx = 1'b1;
  endtask

  task automatic do_read(input string pfx, input logic [7:0] exp_dat);
    rd = 1'b1;
    tick_to(1);
    rd = 1'b0;
    @(negedge clk);
    check({pfx, "_rd_valid"}, 32'(valid), 32'd0);
    check({pfx, "_rd_ferr"}, 32'(ferr), 32'd0);
    check({pfx, "_rd_perr"}, 32'(perr), 32'd0);
    check({pfx, "_rd_ovr"}, 32'(ovr), 32'd0);
    check({pfx, "_rd_dat_hold"}, 32'(dat), 32'(exp_dat));
    tick_to(1);
  endtask

  task automatic rx_and_check(input string pfx, input vec_t v);
    int nv0;
    int lo;
    int hi;
    nv0 = nvalid;
    send_frame(v.data, v.par, v.stop, v.bclk);
    tick_to(BIT);
    @(negedge clk);
    lo = int'(BIT_R * (9.4 + PARITY_ON));
    hi = int'(BIT_R * (9.7 + PARITY_ON));
    check({pfx, "_valid"}, 32'(valid), 32'd1);
    check({pfx, "_nrise"}, 32'(nvalid - nv0), 32'd1);
    check({pfx, "_dat"}, 32'(dat), 32'(v.exp_dat));
    check({pfx, "_ferr"}, 32'(ferr), 32'(v.exp_ferr));
    check({pfx, "_perr"}, 32'(perr), (PARITY_ON != 0) ? 32'(v.exp_perr) : 32'd0);
    check({pfx, "_ovr"}, 32'(ovr), 32'd0);
    check_rng({pfx, "_latency"}, rise_cyc - edge_cyc, lo, hi);
    tick_to(1);
    do_read(pfx, v.exp_dat);
  endtask

  vec_t tbl[9];
  vec_t v;

  initial begin
    int nv0;
    int n;

    tbl[0] = '{8'hA5, 1'b0, 1'b1, BIT,  8'hA5, 1'b0, 1'b0};
    tbl[1] = '{8'h00, 1'b0, 1'b1, BIT,  8'h00, 1'b0, 1'b0};
    tbl[2] = '{8'hFF, 1'b0, 1'b1, BIT,  8'hFF, 1'b0, 1'b0};
    tbl[3] = '{8'h5A, 1'b0, 1'b1, FAST, 8'h5A, 1'b0, 1'b0};
    tbl[4] = '{8'h5A, 1'b0, 1'b1, SLOW, 8'h5A, 1'b0, 1'b0};
    tbl[5] = '{8'h96, 1'b0, 1'b0, BIT,  8'h96, 1'b1, 1'b0};
    tbl[6] = '{8'h07, 1'b1, 1'b1, BIT,  8'h07, 1'b0, 1'b0};
    tbl[7] = '{8'h07, 1'b0, 1'b1, BIT,  8'h07, 1'b0, 1'b1};
    tbl[8] = '{8'hC3, 1'b0, 1'b1, SLOW, 8'hC3, 1'b0, 1'b0};

    // Reset state
    tick_to(5);
    @(negedge clk);
    check("rst_dat", 32'(dat), 32'd0);
    check("rst_valid", 32'(valid), 32'd0);
    check("rst_ferr", 32'(ferr), 32'd0);
    check("rst_perr", 32'(perr), 32'd0);
    check("rst_ovr", 32'(ovr), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    rst_n = 1'b1;
    tick_to(BIT);

    for (int i = 0; i < 9; i++) rx_and_check($sformatf("v%0d", i), tbl[i]);

    // Short low glitch must be rejected
    nv0 = nvalid;
    rx = 1'b0;
    tick_to(50);
    rx = 1'b1;
    tick_to(2 * BIT);
    @(negedge clk);
    check("glitch_busy", 32'(busy), 32'd0);
    check("glitch_valid", 32'(valid), 32'd0);
    check("glitch_nrise", 32'(nvalid - nv0), 32'd0);
    tick_to(1);
    v = '{8'h3C, 1'b0, 1'b1, BIT, 8'h3C, 1'b0, 1'b0};
    rx_and_check("post_glitch", v);

    // Stop bit low, line held low for three frames
    nv0 = nvalid;
    edge_cyc = cyc;
    drive_bit(1'b0, BIT);
    for (int i = 0; i < 8; i++) drive_bit(v.data[i], BIT);
    if (PARITY_ON != 0) drive_bit(1'b0, BIT);
    drive_bit(1'b0, 30 * BIT);
    @(negedge clk);
    check("brk_nrise", 32'(nvalid - nv0), 32'd1);
    check("brk_valid", 32'(valid), 32'd1);
    check("brk_dat", 32'(dat), 32'h3C);
    check("brk_ferr", 32'(ferr), 32'd1);
    check("brk_ovr", 32'(ovr), 32'd0);
    check("brk_busy", 32'(busy), 32'd0);
    tick_to(1);
    rx = 1'b1;
    tick_to(BIT);
    do_read("brk", 8'h3C);
    v = '{8'h81, 1'b0, 1'b1, BIT, 8'h81, 1'b0, 1'b0};
    rx_and_check("post_brk", v);

    // Back-to-back without read -> overrun
    send_frame(8'h11, 1'b0, 1'b1, BIT);
    send_frame(8'h22, 1'b0, 1'b1, BIT);
    tick_to(BIT);
    @(negedge clk);
    check("ovr_dat", 32'(dat), 32'h22);
    check("ovr_valid", 32'(valid), 32'd1);
    check("ovr_flag", 32'(ovr), 32'd1);
    tick_to(1);
    do_read("ovr", 8'h22);

    // Commit in the same clock as a read keeps ovr clear
    send_frame(8'h44, 1'b0, 1'b1, BIT);
    tick_to(BIT);
    @(negedge clk);
    check("cr_pre_valid", 32'(valid), 32'd1);
    tick_to(1);
    fork
      send_frame(8'h55, 1'b0, 1'b1, BIT);
      begin
        n = 0;
        while (!busy && n < 3000) begin @(negedge clk); n++; end
        while (busy && n < 3000) begin @(negedge clk); n++; end
        check("cr_busy_seen", 32'(n < 3000), 32'd1);
        rd = 1'b1;
        @(posedge clk);
        #1;
        rd = 1'b0;
        @(negedge clk);
        check("cr_dat", 32'(dat), 32'h55);
        check("cr_valid", 32'(valid), 32'd1);
        check("cr_ovr", 32'(ovr), 32'd0);
      end
    join
    tick_to(BIT);

    // Reset mid-frame discards the partial byte and the held one
    drive_bit(1'b0, BIT);
    for (int i = 0; i < 4; i++) drive_bit(1'b1, BIT);
    @(negedge clk);
    check("mr_busy_pre", 32'(busy), 32'd1);
    check("mr_valid_pre", 32'(valid), 32'd1);
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    check("mr_dat", 32'(dat), 32'd0);
    check("mr_valid", 32'(valid), 32'd0);
    check("mr_ovr", 32'(ovr), 32'd0);
    check("mr_busy", 32'(busy), 32'd0);
    tick_to(1);
    nv0 = nvalid;
    drive_bit(1'b1, 6 * BIT);
    @(negedge clk);
    check("mr_no_valid", 32'(valid), 32'd0);
    check("mr_nrise", 32'(nvalid - nv0), 32'd0);
    tick_to(1);
    v = '{8'h5A, 1'b0, 1'b1, BIT, 8'h5A, 1'b0, 1'b0};
    rx_and_check("post_rst", v);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
